// File: rtl/filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : filter_sequencer
// Description : Streams NUM_SAMPLES words from a single-port sample BRAM into
//               the filter datapath one sample at a time, and writes each
//               filter result into a result buffer at the matching address.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W      sample / result address width
//   NUM_SAMPLES samples per run, 1 .. 2**ADDR_W
//   TIMEOUT     WAIT watchdog limit in cycles (FILTER_SEQ_TIMEOUT_EN only)
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   start              begin a run (honoured only in IDLE or ERROR)
//   memAddr / memData  BRAM read address (registered) / read data (1-cycle)
//   filtIn             sample to filter, memData[31:14], held until next LATCH
//   filtNewData        one-cycle strobe to the filter
//   filtOut/filtReady  filter result and its single-cycle valid pulse
//   outWrEn/outAddr/outData  result buffer write port
//   busy, done, err    status: running, end-of-run pulse, watchdog fault
// Configuration
//   FILTER_SEQ_TIMEOUT_EN  when defined, adds the WAIT watchdog and the ERROR
//                          state; otherwise err is constant 0.
// ============================================================================
module filter_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int NUM_SAMPLES = 1024,
  parameter int TIMEOUT     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [31:0]       memData,
  output logic [17:0]       filtIn,
  output logic              filtNewData,
  input  logic [17:0]       filtOut,
  input  logic              filtReady,
  output logic              outWrEn,
  output logic [ADDR_W-1:0] outAddr,
  output logic [17:0]       outData,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  // idx carries one extra bit so NUM_SAMPLES = 2**ADDR_W needs no wrap.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_SAMPLES - 1);

  logic [2:0]      r_state;
  logic [ADDR_W:0] r_idx;
  logic [ADDR_W:0] w_idx_next;
  logic            w_last;
  logic            w_timeout;

  // Only the top 18 bits of each sample word feed the filter.
  logic w_unused_mem;
  assign w_unused_mem = ^memData[13:0];

  assign w_idx_next = r_idx + 1'b1;
  assign w_last     = (r_idx == LAST_IDX);

`ifdef FILTER_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;

  // Counts completed WAIT cycles; held at zero outside WAIT so every entry
  // into WAIT starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Fires in the TIMEOUT-th WAIT cycle if the filter still has not answered.
  assign w_timeout = (r_state == S_WAIT) && !filtReady &&
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE || r_state == S_ERROR) && start) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      memAddr     <= '0;
      filtIn      <= '0;
      filtNewData <= 1'b0;
      outWrEn     <= 1'b0;
      outAddr     <= '0;
      outData     <= '0;
    end else begin
      // Both strobes are single-cycle unless re-armed below.
      filtNewData <= 1'b0;
      outWrEn     <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            r_idx   <= '0;
            memAddr <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          filtIn      <= memData[31:14];
          filtNewData <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (filtReady) begin
            outData <= filtOut;
            outAddr <= r_idx[ADDR_W-1:0];
            outWrEn <= 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= w_idx_next;
              memAddr <= w_idx_next[ADDR_W-1:0];
              r_state <= S_FETCH;
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign done = (r_state == S_DONE);

endmodule
`default_nettype wire
